// File: rtl/i2c_pkg.sv
// Shared types for the I2C receive path.
// FSM state encoding and default byte width.
package i2c_pkg;

    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        RXB_IDLE,
        RXB_STORE,
        RXB_ADVANCE
    } rxb_state_t;

endpackage

// File: rtl/i2c_rx_frame_buf_if.sv
// Byte-stream / frame-buffer bundle for i2c_rx_frame_buf.
// I2C_RXBUF_CHK_EN adds the frame checksum signal chk.
interface i2c_rx_frame_buf_if
    import i2c_pkg::*;
#(
    parameter int DEPTH  = 11,
    parameter int DATA_W = I2C_DATA_W,
    parameter int IDX_W  = $clog2(DEPTH)
);

    logic                    rx_done;
    logic [DATA_W-1:0]       rx_data;
    logic                    clr;
    logic [DEPTH*DATA_W-1:0] tx_data_buf;
    logic [IDX_W-1:0]        wr_idx;
    logic                    frame_done;
    logic                    full;
    logic                    overrun;

`ifdef I2C_RXBUF_CHK_EN
    logic [DATA_W-1:0]       chk;

    modport master (
        output rx_done, rx_data, clr,
        input  tx_data_buf, wr_idx, frame_done,
        input  full, overrun, chk
    );
    modport slave (
        input  rx_done, rx_data, clr,
        output tx_data_buf, wr_idx, frame_done,
        output full, overrun, chk
    );
`else
    modport master (
        output rx_done, rx_data, clr,
        input  tx_data_buf, wr_idx, frame_done,
        input  full, overrun
    );
    modport slave (
        input  rx_done, rx_data, clr,
        output tx_data_buf, wr_idx, frame_done,
        output full, overrun
    );
`endif

endinterface

// File: rtl/i2c_rx_frame_buf_ptr.sv
// Write pointer for the receive frame buffer:
// increment, wrap or stop at the last slot, full and frame_done.
module rxbuf_ptr #(
    parameter int DEPTH = 11,
    parameter int WRAP  = 1,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             store,
    output logic [IDX_W-1:0] wr_idx,
    output logic             full,
    output logic             frame_done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    // Explicit compare against LAST so non-power-of-2 depths wrap correctly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx     <= '0;
            full       <= 1'b0;
            frame_done <= 1'b0;
        end else if (clr) begin
            wr_idx     <= '0;
            full       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (store) begin
                if (wr_idx == LAST) begin
                    frame_done <= 1'b1;
                    if (WRAP != 0) begin
                        wr_idx <= '0;
                    end else begin
                        full <= 1'b1;
                    end
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_rx_frame_buf.sv
// Receive frame buffer: stores strobed bytes into DEPTH slots for loopback.
// Define I2C_RXBUF_CHK_EN to add the per-frame XOR checksum output chk.
module i2c_rx_frame_buf
    import i2c_pkg::*;
#(
    parameter int DEPTH  = 11,
    parameter int DATA_W = I2C_DATA_W,
    parameter int WRAP   = 1,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    i2c_rx_frame_buf_if.slave bus
);

    rxb_state_t        state;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] slots [DEPTH];
    logic              overrun;
    logic [IDX_W-1:0]  wr_idx;
    logic              full;
    logic              frame_done;

`ifdef I2C_RXBUF_CHK_EN
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    logic [DATA_W-1:0] run_x;
    logic [DATA_W-1:0] chk;
`endif

    rxbuf_ptr #(
        .DEPTH (DEPTH),
        .WRAP  (WRAP),
        .IDX_W (IDX_W)
    ) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .clr        (bus.clr),
        .store      (state == RXB_STORE),
        .wr_idx     (wr_idx),
        .full       (full),
        .frame_done (frame_done)
    );

    // clr wins over everything, including a pending STORE write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RXB_IDLE;
            hold    <= '0;
            overrun <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
`ifdef I2C_RXBUF_CHK_EN
            run_x <= '0;
            chk   <= '0;
`endif
        end else if (bus.clr) begin
            state   <= RXB_IDLE;
            overrun <= 1'b0;
`ifdef I2C_RXBUF_CHK_EN
            run_x <= '0;
            chk   <= '0;
`endif
        end else begin
            unique case (state)
                RXB_IDLE: begin
                    if (bus.rx_done) begin
                        if (full) begin
                            overrun <= 1'b1;
                        end else begin
                            hold  <= bus.rx_data;
                            state <= RXB_STORE;
                        end
                    end
                end
                RXB_STORE: begin
                    slots[wr_idx] <= hold;
`ifdef I2C_RXBUF_CHK_EN
                    if (wr_idx == LAST) begin
                        chk   <= run_x ^ hold;
                        run_x <= '0;
                    end else begin
                        run_x <= run_x ^ hold;
                    end
`endif
                    if (bus.rx_done) overrun <= 1'b1;
                    state <= RXB_ADVANCE;
                end
                RXB_ADVANCE: begin
                    if (bus.rx_done) overrun <= 1'b1;
                    state <= RXB_IDLE;
                end
                default: state <= RXB_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign bus.tx_data_buf[k*DATA_W +: DATA_W] = slots[k];
    end

    assign bus.wr_idx     = wr_idx;
    assign bus.full       = full;
    assign bus.frame_done = frame_done;
    assign bus.overrun    = overrun;
`ifdef I2C_RXBUF_CHK_EN
    assign bus.chk        = chk;
`endif

endmodule

// File: tb/tb_i2c_rx_frame_buf.sv
// Bench for i2c_rx_frame_buf: a wrapping 11-slot and a stopping 4-slot
// instance checked every cycle against a timestamp-based frame model.
module tb_i2c_rx_frame_buf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       rd   [2] = '{1'b0, 1'b0};
    logic [7:0] rdat [2] = '{8'h00, 8'h00};
    logic       cl   [2] = '{1'b0, 1'b0};

    i2c_rx_frame_buf_if #(.DEPTH(11), .DATA_W(8)) if0 ();
    i2c_rx_frame_buf_if #(.DEPTH(4),  .DATA_W(8)) if1 ();

    assign if0.rx_done = rd[0];
    assign if0.rx_data = rdat[0];
    assign if0.clr     = cl[0];
    assign if1.rx_done = rd[1];
    assign if1.rx_data = rdat[1];
    assign if1.clr     = cl[1];

    i2c_rx_frame_buf #(.DEPTH(11), .DATA_W(8), .WRAP(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    i2c_rx_frame_buf #(.DEPTH(4), .DATA_W(8), .WRAP(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;
    int fd_cnt0 = 0;

    task automatic check(string name, logic [87:0] act, logic [87:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte accepted at edge t is stored at edge t+1; the next
    // accept is only possible from edge t+3 on. Anything else is an overrun.
    int         ecnt = 0;
    logic [7:0] m_slot [2][11];
    int         m_wr   [2];
    bit         m_full [2];
    bit         m_ovr  [2];
    bit         m_fd   [2];
    logic [7:0] m_run  [2];
    logic [7:0] m_chk  [2];
    int         last_acc [2];
    bit         pend   [2];
    int         pend_e [2];
    logic [7:0] pend_d [2];

    function automatic int dep_of(int i);
        return (i == 0) ? 11 : 4;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 11; k++) m_slot[i][k] = 8'h00;
            m_wr[i] = 0; m_full[i] = 0; m_ovr[i] = 0; m_fd[i] = 0;
            m_run[i] = 8'h00; m_chk[i] = 8'h00;
            last_acc[i] = -100; pend[i] = 0; pend_e[i] = 0; pend_d[i] = 8'h00;
        end
    endtask

    task automatic mstep(int i);
        int dep;
        dep = dep_of(i);
        if (cl[i]) begin
            m_wr[i] = 0; m_full[i] = 0; m_ovr[i] = 0; m_fd[i] = 0;
            m_run[i] = 8'h00; m_chk[i] = 8'h00;
            pend[i] = 0; last_acc[i] = -100;
            return;
        end
        m_fd[i] = 0;
        if (pend[i] && pend_e[i] == ecnt) begin
            pend[i] = 0;
            m_slot[i][m_wr[i]] = pend_d[i];
            if (m_wr[i] == dep - 1) begin
                m_fd[i]  = 1;
                m_chk[i] = m_run[i] ^ pend_d[i];
                m_run[i] = 8'h00;
                if (i == 0) m_wr[i] = 0;
                else m_full[i] = 1;
            end else begin
                m_run[i] = m_run[i] ^ pend_d[i];
                m_wr[i]  = m_wr[i] + 1;
            end
        end
        if (rd[i]) begin
            if (ecnt - last_acc[i] < 3 || m_full[i]) begin
                m_ovr[i] = 1;
            end else begin
                last_acc[i] = ecnt;
                pend[i] = 1; pend_e[i] = ecnt + 1; pend_d[i] = rdat[i];
            end
        end
    endtask

    function automatic logic [87:0] exp_tx(int i);
        logic [87:0] v;
        v = '0;
        for (int k = 0; k < dep_of(i); k++) v[k*8 +: 8] = m_slot[i][k];
        return v;
    endfunction

    initial mreset();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mreset();
        end else begin
            ecnt++;
            mstep(0);
            mstep(1);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("tx0",  if0.tx_data_buf, exp_tx(0));
            check("wr0",  88'(if0.wr_idx), 88'(m_wr[0]));
            check("fd0",  88'(if0.frame_done), 88'(m_fd[0]));
            check("full0", 88'(if0.full), 88'(m_full[0]));
            check("ovr0", 88'(if0.overrun), 88'(m_ovr[0]));
            check("tx1",  88'(if1.tx_data_buf), exp_tx(1));
            check("wr1",  88'(if1.wr_idx), 88'(m_wr[1]));
            check("fd1",  88'(if1.frame_done), 88'(m_fd[1]));
            check("full1", 88'(if1.full), 88'(m_full[1]));
            check("ovr1", 88'(if1.overrun), 88'(m_ovr[1]));
`ifdef I2C_RXBUF_CHK_EN
            check("chk0", 88'(if0.chk), 88'(m_chk[0]));
            check("chk1", 88'(if1.chk), 88'(m_chk[1]));
`endif
            if (if0.frame_done) fd_cnt0++;
        end
    end

    task automatic send(int i, logic [7:0] d, int gap);
        @(negedge clk);
        rd[i] = 1'b1; rdat[i] = d;
        @(negedge clk);
        rd[i] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_clr(int i);
        @(negedge clk);
        cl[i] = 1'b1;
        @(negedge clk);
        cl[i] = 1'b0;
    endtask

    int fd_base;

    initial begin
        #1 rst = 1'b1;
        #1 started = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx0", if0.tx_data_buf, 88'h0);
        check("rst_wr0", 88'(if0.wr_idx), 88'h0);
        check("rst_tx1", 88'(if1.tx_data_buf), 88'h0);
        rst = 1'b0;

        // one full wrapping frame
        fd_base = fd_cnt0;
        for (int b = 0; b < 11; b++) send(0, 8'(b), 9);
        check("frame_tx0", if0.tx_data_buf, 88'h0A09080706050403020100);
        check("frame_wr0", 88'(if0.wr_idx), 88'h0);
        check("frame_fd_cnt", 88'(fd_cnt0 - fd_base), 88'h1);
`ifdef I2C_RXBUF_CHK_EN
        check("frame_chk0", 88'(if0.chk), 88'h0B);
`endif
        send(0, 8'hFF, 9);
        check("wrap_tx0", if0.tx_data_buf, 88'h0A090807060504030201FF);
        check("wrap_wr0", 88'(if0.wr_idx), 88'h1);

        // stop-at-full instance
        send(1, 8'hA1, 4);
        send(1, 8'hA2, 4);
        send(1, 8'hA3, 4);
        send(1, 8'hA4, 4);
        check("stop_full1", 88'(if1.full), 88'h1);
        check("stop_wr1", 88'(if1.wr_idx), 88'h3);
        send(1, 8'hA5, 4);
        check("stop_ovr1", 88'(if1.overrun), 88'h1);
        check("stop_tx1", 88'(if1.tx_data_buf), 88'hA4A3A2A1);
        pulse_clr(1);
        check("clr_full1", 88'(if1.full), 88'h0);
        check("clr_ovr1", 88'(if1.overrun), 88'h0);
        send(1, 8'hB6, 4);
        check("clr_tx1", 88'(if1.tx_data_buf), 88'hA4A3A2B6);
        check("clr_wr1", 88'(if1.wr_idx), 88'h1);

        // back-to-back strobes
        pulse_clr(0);
        @(negedge clk);
        rd[0] = 1'b1; rdat[0] = 8'h11;
        @(negedge clk);
        rdat[0] = 8'h22;
        @(negedge clk);
        rd[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_slot0", 88'(if0.tx_data_buf[7:0]), 88'h11);
        check("b2b_ovr0", 88'(if0.overrun), 88'h1);
        check("b2b_wr0", 88'(if0.wr_idx), 88'h1);

        // clr together with rx_done
        @(negedge clk);
        rd[0] = 1'b1; rdat[0] = 8'h33; cl[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0; cl[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("clrrx_ovr0", 88'(if0.overrun), 88'h0);
        check("clrrx_wr0", 88'(if0.wr_idx), 88'h0);
        check("clrrx_slot0", 88'(if0.tx_data_buf[7:0]), 88'h11);

        // async reset in the STORE cycle of the third byte
        send(0, 8'h01, 3);
        send(0, 8'h02, 3);
        @(negedge clk);
        rd[0] = 1'b1; rdat[0] = 8'h03;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_tx0", if0.tx_data_buf, 88'h0);
        check("arst_wr0", 88'(if0.wr_idx), 88'h0);
        check("arst_fd0", 88'(if0.frame_done), 88'h0);
        check("arst_full1", 88'(if1.full), 88'h0);
        check("arst_ovr0", 88'(if0.overrun), 88'h0);
        @(negedge clk);
        rd[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(0, 8'h5A, 4);
        check("post_rst_tx0", if0.tx_data_buf, 88'h5A);
        check("post_rst_wr0", 88'(if0.wr_idx), 88'h1);

        // randomized traffic on both instances
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rd[i]   = ($urandom_range(0, 2) == 0);
                rdat[i] = 8'($urandom);
                cl[i]   = ($urandom_range(0, 50) == 0);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0;
            cl[i] = 1'b0;
        end
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
